vdma_buffer_point_ctrl: RTL

VDMA_BUFFER_POINT_CTRL -- requirements
Module: vdma_buffer_point_ctrl

---
 rtl/vdma_buf_pkg.sv | 30 +++
 rtl/vdma_vs_edge.sv | 33 +++
 rtl/vdma_buffer_point_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vdma_buf_pkg.sv
// -----------------------------------------------------------------------------
// vdma_buf_pkg
// Shared types and helpers for the VDMA frame-buffer pointer controller.
//   point_t      : frame-buffer index (up to 8 buffers)
//   MAX_BUF_NUM  : largest supported buffer count
//   next_point() : advance a pointer by one modulo num, stepping over 'skip'
// -----------------------------------------------------------------------------
package vdma_buf_pkg;

    typedef logic [2:0] point_t;

    localparam int MAX_BUF_NUM = 8;

    // Returns (cur+1) mod num; if that lands on 'skip' it advances once more.
    // With num==2 the second step folds back onto 'cur', which the caller
    // treats as "no free buffer".
    function automatic point_t next_point(input point_t     cur,
                                          input point_t     skip,
                                          input logic [3:0] num);
        logic [3:0] cand;
        cand = {1'b0, cur} + 4'd1;
        if (cand >= num) cand = 4'd0;
        if (cand[2:0] == skip) begin
            cand = cand + 4'd1;
            if (cand >= num) cand = 4'd0;
        end
        return cand[2:0];
    endfunction

endpackage

// File: rtl/vdma_vs_edge.sv
// -----------------------------------------------------------------------------
// vdma_vs_edge
// Two-flop registration of a clk-synchronous vsync plus a rising-edge term.
// A vsync held high yields exactly one vs_rise cycle.
//   clk     : clock
//   rst     : asynchronous active-high reset (clears history)
//   vs      : vsync input
//   vs_rise : combinational rising-edge term (vs_p0 & ~vs_p1)
// -----------------------------------------------------------------------------
module vdma_vs_edge (
    input  logic clk,
    input  logic rst,
    input  logic vs,
    output logic vs_rise
);

    logic vs_p0;
    logic vs_p1;

    // stage 0/1: vsync history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_p0 <= 1'b0;
            vs_p1 <= 1'b0;
        end else begin
            vs_p0 <= vs;
            vs_p1 <= vs_p0;
        end
    end

    assign vs_rise = vs_p0 & ~vs_p1;

endmodule

// File: rtl/vdma_buffer_point_ctrl.sv
// -----------------------------------------------------------------------------
// vdma_buffer_point_ctrl
// Rotates BUF_NUM frame buffers between a write master and a read master.
// The writer never fills the buffer being read (BUF_NUM>=3); the reader
// always moves to the most recently completed frame, or repeats its current
// one when nothing newer exists.
//
// Ports
//   clk, rst                   : clock, asynchronous active-high reset
//   wr_vs, rd_vs               : write / read vsync (rising edge = new frame)
//   wr_point, rd_point         : current write / read buffer index
//   wr_baseaddr, rd_baseaddr   : registered byte address of those buffers
//   wr_drop                    : one-cycle pulse, write reuses its buffer
//   rd_repeat                  : one-cycle pulse, read repeats its buffer
//   wr_drop_cnt, rd_repeat_cnt : saturating pulse counters, present only
//                                when VDMA_BUF_STAT_EN is defined
// -----------------------------------------------------------------------------
module vdma_buffer_point_ctrl
    import vdma_buf_pkg::*;
#(
    parameter int                    BUF_NUM      = 3,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = 32'h0080_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_vs,
    input  logic                  rd_vs,
    output logic [2:0]            wr_point,
    output logic [2:0]            rd_point,
    output logic [ADDR_WIDTH-1:0] wr_baseaddr,
    output logic [ADDR_WIDTH-1:0] rd_baseaddr,
    output logic                  wr_drop,
    output logic                  rd_repeat
`ifdef VDMA_BUF_STAT_EN
    ,
    output logic [15:0]           wr_drop_cnt,
    output logic [15:0]           rd_repeat_cnt
`endif
);

    localparam logic [3:0] NUM = 4'(BUF_NUM);

    logic   wr_rise;
    logic   rd_rise;
    point_t latest;
    logic   latest_valid;

    point_t wr_nxt;
    point_t rd_nxt;
    point_t latest_nxt;
    logic   latest_valid_nxt;
    logic   drop_nxt;
    logic   repeat_nxt;

    function automatic logic [ADDR_WIDTH-1:0] point_addr(input point_t p);
        return BASE_ADDR + ADDR_WIDTH'(p) * FRAME_STRIDE;
    endfunction

    vdma_vs_edge u_wr_edge (.clk(clk), .rst(rst), .vs(wr_vs), .vs_rise(wr_rise));
    vdma_vs_edge u_rd_edge (.clk(clk), .rst(rst), .vs(rd_vs), .vs_rise(rd_rise));

    // Read is resolved first so the write can skip the buffer the reader
    // lands on in the same cycle.
    always_comb begin
        wr_nxt           = wr_point;
        rd_nxt           = rd_point;
        latest_nxt       = latest;
        latest_valid_nxt = latest_valid;
        drop_nxt         = 1'b0;
        repeat_nxt       = 1'b0;

        if (rd_rise) begin
            if (wr_rise) begin
                // The frame finishing right now is the newest one.
                if (wr_point != rd_point) rd_nxt = wr_point;
                else                      repeat_nxt = 1'b1;
            end else if (latest_valid && (latest != rd_point)) begin
                rd_nxt = latest;
            end else begin
                repeat_nxt = 1'b1;
            end
        end

        if (wr_rise) begin
            latest_nxt       = wr_point;
            latest_valid_nxt = 1'b1;
            wr_nxt           = next_point(wr_point, rd_nxt, NUM);
            // Only possible with two buffers: the sole candidate is being read.
            drop_nxt         = (wr_nxt == wr_point);
        end
    end

    // stage 1: pointer state and pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_point     <= 3'd1;
            rd_point     <= 3'd0;
            latest       <= 3'd0;
            latest_valid <= 1'b0;
            wr_drop      <= 1'b0;
            rd_repeat    <= 1'b0;
        end else begin
            wr_point     <= wr_nxt;
            rd_point     <= rd_nxt;
            latest       <= latest_nxt;
            latest_valid <= latest_valid_nxt;
            wr_drop      <= drop_nxt;
            rd_repeat    <= repeat_nxt;
        end
    end

    // stage 2: base addresses follow their pointers by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_baseaddr <= BASE_ADDR + FRAME_STRIDE;
            rd_baseaddr <= BASE_ADDR;
        end else begin
            wr_baseaddr <= point_addr(wr_point);
            rd_baseaddr <= point_addr(rd_point);
        end
    end

`ifdef VDMA_BUF_STAT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counters step together with the pulse they count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_drop_cnt   <= 16'd0;
            rd_repeat_cnt <= 16'd0;
        end else begin
            if (drop_nxt)   wr_drop_cnt   <= sat_inc(wr_drop_cnt);
            if (repeat_nxt) rd_repeat_cnt <= sat_inc(rd_repeat_cnt);
        end
    end
`endif

endmodule
